ps2_scan_rx: RTL and testbench
==============================

Name: ps2_scan_rx

Overview:
- PS/2 keyboard receiver that sits directly upstream of the seven-segment decoder.
- Synchronises and filters the raw PS/2 clock/data lines, then deframes 11-bit frames and checks odd parity.
- Strips break (F0) and extended (E0) sequences.
- Presents the most recent plain make code as a held 8-bit value plus an enable that drive the decoder's value/en inputs directly.

Parameters:
- FILTER_LEN, 8, number of consecutive identical synchronised ps2_clk samples required to accept a new filtered level.
- TIMEOUT, 50000, clk cycles without a filtered falling edge before a partial frame is discarded (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the connector, asynchronous.
- ps2_data  in  1  raw PS/2 data from the connector, asynchronous.
- scan_code  out  8  last accepted make code, held until the next one arrives.
- code_valid  out  1  high once any make code has been accepted; feeds the decoder enable.
- code_strobe  out  1  one-cycle pulse in the cycle scan_code updates.
- frame_err  out  1  one-cycle pulse on a parity, start or stop error, or on a timeout.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - scan_code=8'h00, code_valid=0, code_strobe=0, frame_err=0.
  - State=IDLE; break_pend=0, ext_pend=0.
  - Synchronisers and filter preset to 1 (idle bus level).
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - Filtered clock changes level only after FILTER_LEN consecutive equal synchronised samples.
  - fall = filtered clock 1->0, a single-cycle event. Data is sampled from the synchronised ps2_data in the fall cycle.
- Deframing FSM (advances only on fall, apart from timeout):
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay in IDLE and pulse frame_err.
  - DATA: shift right, new bit into MSB (LSB-first frame). After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: always returns to IDLE. If stop bit=1 and ^{byte,parity}=1 (odd parity), the byte is "received". Otherwise pulse frame_err and drop the byte.
- Timeout:
  - A counter resets on every fall and while in IDLE.
  - If it reaches TIMEOUT outside IDLE: go to IDLE, pulse frame_err, clear the shift register. break_pend and ext_pend are left unchanged.
- Byte interpretation, one cycle after STOP, registered:
  - 8'hF0: set break_pend.
  - 8'hE0: set ext_pend.
  - Any other byte with break_pend or ext_pend set: discard it, clear both flags, no strobe.
  - Otherwise (plain make code): scan_code<=byte, code_valid<=1, code_strobe=1 for exactly one cycle.
- Latency: code_strobe asserts 2 clk cycles after the fall cycle that sampled the stop bit (1 cycle for the check, 1 for the register).
- Typematic repeat of the same make code is accepted: it re-strobes with an unchanged scan_code.
- code_valid never deasserts except on reset.
- Reset mid-frame: the frame is abandoned immediately. The first frame after reset release is decoded normally only if its start bit arrives after release.
- Glitches shorter than FILTER_LEN cycles on ps2_clk produce no fall.
- The block never drives the PS/2 lines (receive only).

Test Plan:
- Reset, then a frame for 8'h1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), bit period 4000 clk -> scan_code=8'h1C, code_valid=1, one code_strobe 2 cycles after the stop fall.
- Sequence 8'h16, F0, 16, 8'h3E -> exactly two strobes, with scan_code 8'h16 then 8'h3E. scan_code stays 8'h16 through the break pair.
- E0 then 8'h75 -> no strobe, scan_code unchanged. A following 8'h24 -> strobe, scan_code=8'h24.
- 8'h32 sent with a flipped parity bit -> frame_err pulses once, no strobe. The next valid 8'h23 is received correctly.
- Five data bits, then bus idle for 60000 cycles -> frame_err at TIMEOUT, FSM back in IDLE. A following full 8'h2B frame decodes correctly.
- 3-cycle low glitches on ps2_clk during idle -> no state change, no frame_err. rst_n pulled low mid-frame -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard receiver: line conditioning, deframing, break/extended stripping.
// Holds the latest plain make code for the seven-segment decoder's value/en inputs.
module ps2_scan_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       code_strobe,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_vld_q, byte_vld_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [7:0]    scan_q, scan_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;
  logic          fall;

  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    fcnt_d     = fcnt_q;
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_cnt_d   = to_cnt_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    brk_d      = brk_q;
    ext_d      = ext_q;
    scan_d     = scan_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;

    // The filtered level only follows after FILTER_LEN consecutive disagreeing samples.
    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_d = clk_s2_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;

    if (state_q == S_IDLE || fall) to_cnt_d = '0;
    else                           to_cnt_d = to_cnt_q + 1'b1;

    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d = S_DATA;
            bcnt_d  = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) begin
            byte_d     = shift_q;
            byte_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != S_IDLE && to_cnt_q >= TW'(TIMEOUT - 1)) begin
      state_d = S_IDLE;
      shift_d = '0;
      err_d   = 1'b1;
    end

    // Prefix bytes arm a flag; the byte that follows a prefix is swallowed.
    if (byte_vld_q) begin
      if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        scan_d   = byte_q;
        valid_d  = 1'b1;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= S_IDLE;
      bcnt_q     <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      byte_q     <= 8'h00;
      byte_vld_q <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      scan_q     <= 8'h00;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      scan_q     <= scan_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
    end
  end

  assign scan_code   = scan_q;
  assign code_valid  = valid_q;
  assign code_strobe = strobe_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb/tb_ps2_scan_rx.sv - bench for ps2_scan_rx against a byte-level keyboard model.
module tb_ps2_scan_rx;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       code_strobe;
  logic       frame_err;

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .code_strobe(code_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;
  int last_strobe_cyc = 0;
  int stop_cyc = 0;
  logic [7:0] strobe_codes[$];

  bit         m_brk, m_ext, m_valid;
  logic [7:0] m_scan;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_strobe) begin
      strobe_cnt++;
      strobe_codes.push_back(scan_code);
      last_strobe_cyc = cyc;
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_valid = 0; m_scan = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // Sends one full frame and reports observed vs. model-predicted strobe/error counts.
  task automatic run_frame(input logic [7:0] b, input bit bad_par,
                           output int ds, output int de, output int eds, output int ede);
    int s0, e0;
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(b, bad_par, 11);
    ds = strobe_cnt - s0; de = err_cnt - e0;
    eds = 0; ede = 0;
    if (bad_par) ede = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk || m_ext) begin m_brk = 0; m_ext = 0; end
    else begin m_scan = b; m_valid = 1; eds = 1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 4;
    if (scan_code !== 8'h00) begin bad++; $display("FAIL reset_scan got=%h want=00", scan_code); end
    if (code_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", code_valid); end
    if (code_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b want=0", code_strobe); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
    rst_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_make_1c();
    int ds, de, eds, ede;
    run_frame(8'h1C, 0, ds, de, eds, ede);
    total += 5;
    if (ds !== eds) begin bad++; $display("FAIL make1c_strobes got=%0d want=%0d", ds, eds); end
    if (de !== ede) begin bad++; $display("FAIL make1c_errs got=%0d want=%0d", de, ede); end
    if (scan_code !== 8'h1C) begin bad++; $display("FAIL make1c_scan got=%h want=1c", scan_code); end
    if (code_valid !== 1'b1) begin bad++; $display("FAIL make1c_valid got=%b want=1", code_valid); end
    // 2 sync flops + FILTER_LEN filter samples to the fall, +1 for the registered strobe
    if (last_strobe_cyc - stop_cyc !== FL + 3) begin
      bad++; $display("FAIL make1c_latency got=%0d want=%0d", last_strobe_cyc - stop_cyc, FL + 3);
    end
  endtask

  task automatic test_break();
    int ds, de, eds, ede, n0;
    logic [7:0] seq [4];
    logic [7:0] c0, c1;
    seq = '{8'h16, 8'hF0, 8'h16, 8'h3E};
    n0 = strobe_codes.size();
    for (int i = 0; i < 4; i++) begin
      run_frame(seq[i], 0, ds, de, eds, ede);
      total++;
      if (scan_code !== m_scan) begin bad++; $display("FAIL break_scan%0d got=%h want=%h", i, scan_code, m_scan); end
    end
    total++;
    if (strobe_codes.size() - n0 !== 2) begin
      bad++; $display("FAIL break_strobes got=%0d want=2", strobe_codes.size() - n0);
    end else begin
      c0 = strobe_codes[n0]; c1 = strobe_codes[n0 + 1];
      total += 2;
      if (c0 !== 8'h16) begin bad++; $display("FAIL break_code0 got=%h want=16", c0); end
      if (c1 !== 8'h3E) begin bad++; $display("FAIL break_code1 got=%h want=3e", c1); end
    end
  endtask

  task automatic test_ext();
    int ds, de, eds, ede, acc;
    acc = 0;
    run_frame(8'hE0, 0, ds, de, eds, ede); acc += ds;
    run_frame(8'h75, 0, ds, de, eds, ede); acc += ds;
    total += 2;
    if (acc !== 0) begin bad++; $display("FAIL ext_strobes got=%0d want=0", acc); end
    if (scan_code !== 8'h3E) begin bad++; $display("FAIL ext_scan got=%h want=3e", scan_code); end
    run_frame(8'h24, 0, ds, de, eds, ede);
    total += 2;
    if (ds !== 1) begin bad++; $display("FAIL ext_next_strobe got=%0d want=1", ds); end
    if (scan_code !== 8'h24) begin bad++; $display("FAIL ext_next_scan got=%h want=24", scan_code); end
  endtask

  task automatic test_parity();
    int ds, de, eds, ede;
    run_frame(8'h32, 1, ds, de, eds, ede);
    total += 2;
    if (de !== 1) begin bad++; $display("FAIL parity_err got=%0d want=1", de); end
    if (ds !== 0) begin bad++; $display("FAIL parity_strobe got=%0d want=0", ds); end
    run_frame(8'h23, 0, ds, de, eds, ede);
    total += 2;
    if (ds !== 1 || de !== 0) begin bad++; $display("FAIL parity_next_counts got=%0d/%0d want=1/0", ds, de); end
    if (scan_code !== 8'h23) begin bad++; $display("FAIL parity_next_scan got=%h want=23", scan_code); end
  endtask

  task automatic test_timeout();
    int ds, de, eds, ede, e0;
    e0 = err_cnt;
    send_frame(8'h55, 0, 6);
    repeat (TO - 200) @(negedge clk);
    total++;
    if (err_cnt - e0 !== 0) begin bad++; $display("FAIL timeout_early got=%0d want=0", err_cnt - e0); end
    repeat (400) @(negedge clk);
    total++;
    if (err_cnt - e0 !== 1) begin bad++; $display("FAIL timeout_err got=%0d want=1", err_cnt - e0); end
    run_frame(8'h2B, 0, ds, de, eds, ede);
    total += 2;
    if (ds !== 1 || de !== 0) begin bad++; $display("FAIL timeout_next_counts got=%0d/%0d want=1/0", ds, de); end
    if (scan_code !== 8'h2B) begin bad++; $display("FAIL timeout_next_scan got=%h want=2b", scan_code); end
  endtask

  task automatic test_glitch();
    int s0, e0, ds, de, eds, ede;
    s0 = strobe_cnt; e0 = err_cnt;
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    total += 2;
    if (err_cnt - e0 !== 0) begin bad++; $display("FAIL glitch_err got=%0d want=0", err_cnt - e0); end
    if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL glitch_strobe got=%0d want=0", strobe_cnt - s0); end
    run_frame(8'h1B, 0, ds, de, eds, ede);
    total++;
    if (scan_code !== 8'h1B) begin bad++; $display("FAIL glitch_next_scan got=%h want=1b", scan_code); end
  endtask

  task automatic test_random();
    int ds, de, eds, ede;
    logic [7:0] b;
    bit bp;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = m_scan;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 7) == 0);
      run_frame(b, bp, ds, de, eds, ede);
      total += 4;
      if (ds !== eds) begin bad++; $display("FAIL rand%0d_strobe byte=%h got=%0d want=%0d", i, b, ds, eds); end
      if (de !== ede) begin bad++; $display("FAIL rand%0d_err byte=%h got=%0d want=%0d", i, b, de, ede); end
      if (scan_code !== m_scan) begin bad++; $display("FAIL rand%0d_scan got=%h want=%h", i, scan_code, m_scan); end
      if (code_valid !== m_valid) begin bad++; $display("FAIL rand%0d_valid got=%b want=%b", i, code_valid, m_valid); end
    end
  endtask

  task automatic test_reset_midframe();
    int ds, de, eds, ede;
    send_frame(8'h5A, 0, 5);
    #1 rst_n = 1'b0;
    #1;
    total += 4;
    if (scan_code !== 8'h00) begin bad++; $display("FAIL midrst_scan got=%h want=00", scan_code); end
    if (code_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", code_valid); end
    if (code_strobe !== 1'b0) begin bad++; $display("FAIL midrst_strobe got=%b want=0", code_strobe); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b want=0", frame_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    run_frame(8'h45, 0, ds, de, eds, ede);
    total += 2;
    if (ds !== 1 || de !== 0) begin bad++; $display("FAIL midrst_next_counts got=%0d/%0d want=1/0", ds, de); end
    if (scan_code !== 8'h45) begin bad++; $display("FAIL midrst_next_scan got=%h want=45", scan_code); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make_1c();
    test_break();
    test_ext();
    test_parity();
    test_timeout();
    test_glitch();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
